retire_unit: RTL and testbench
==============================

RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 Parameter RET_COUNT, default 4, SHALL set the number of ROB head slots examined per cycle.
REQ-002 Parameter RETCOUNTLOG2, default $clog2(RET_COUNT), SHALL set the consume_count width.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 slot_data[RET_COUNT]  in  rob_entry_t  ROB head entries, slot 0 oldest.
REQ-006 slot_valid[RET_COUNT]  in  1  entry result written and inside used range.
REQ-007 rob_empty  in  1  ROB holds no entries.
REQ-008 consume  out  1  retire at least one entry this cycle.
REQ-009 consume_count  out  RETCOUNTLOG2  entries retired minus one.
REQ-010 rf_wr_en[RET_COUNT] / rf_wr_reg[RET_COUNT] / rf_wr_data[RET_COUNT]  out  1/5/32  architectural register writes.
REQ-011 hilo_wr_en  out  1; hi_data, lo_data  out  32 each  HI/LO commit.
REQ-012 st_commit  out  1  release oldest pending store; st_ready  in  1  store queue can accept a release.
REQ-013 exc_flush  out  1  pipeline-wide flush pulse; exc_pc  out  32  PC of excepting instruction.
REQ-014 retired_count  out  32  running count of retired instructions.

Function
REQ-015 In RUN, the retire group SHALL be the longest prefix of slots 0..RET_COUNT-1 with slot_valid=1, truncated before the first slot that is: a second store; a store while st_ready=0; a second HI/LO writer; or has exception=1.
REQ-016 consume SHALL be 1 iff the group is non-empty, and consume_count SHALL be group size minus one; both are combinational, with zero-cycle latency.
REQ-017 rf_wr_en[i] SHALL be 1 iff slot i is in the group, dest_reg_valid=1, dest_reg!=0, and no later group slot writes the same dest_reg (youngest wins).
REQ-018 rf_wr_reg[i]/rf_wr_data[i] SHALL equal slot i dest_reg/result_lo regardless of rf_wr_en.
REQ-019 hilo_wr_en SHALL be 1 when a group slot has hilo_write=1; hi_data/lo_data SHALL come from that slot's result_hi/result_lo.
REQ-020 st_commit SHALL be 1 when a group slot has is_store=1 (st_ready is necessarily 1).
REQ-021 If slot 0 is valid with exception=1 in RUN, the unit SHALL retire nothing, latch exc_pc=slot 0 pc, and enter EXC_FLUSH on the next edge.
REQ-022 An excepting slot k>0 SHALL NOT stop older slots 0..k-1 from retiring that cycle; slot k reaches slot 0 the next cycle.
REQ-023 EXC_FLUSH SHALL last exactly one cycle with exc_flush=1, then go to EXC_WAIT.
REQ-024 EXC_WAIT SHALL retire nothing and return to RUN on the first edge with rob_empty=1.
REQ-025 In EXC_FLUSH and EXC_WAIT, consume, rf_wr_en, hilo_wr_en and st_commit SHALL be 0.
REQ-026 retired_count SHALL add consume_count+1 on each edge with consume=1 and wrap modulo 2^32.
REQ-027 exc_pc SHALL hold its value until the next exception latch.

Reset
REQ-028 On a reset_n=0 edge, the state SHALL become RUN, retired_count=0, exc_pc=0 and exc_flush=0, with reset taking priority over any operation in progress, including EXC_WAIT.
REQ-029 While reset_n=0, all combinational outputs SHALL be 0.

Structure
REQ-030 rob_entry_t in pipTypes SHALL gain the fields pc[31:0], result_hi[31:0], is_store, hilo_write and exception.
REQ-031 The state enum retire_state_t (RUN, EXC_FLUSH, EXC_WAIT) SHALL live in pipTypes.
REQ-032 Group-boundary detection SHALL be one sub-module, retire_select, which is combinational, outputs the group size and per-slot in-group bits, and is reusable for variable RET_COUNT.

Verification
REQ-033 4 valid ALU slots writing r1,r2,r3,r4 -> consume=1, consume_count=3, all four rf_wr_en=1, and retired_count advances by 4.
REQ-034 slot_valid=1,1,0,1 -> consume_count=1, and slot 3 is not written.
REQ-035 Slots 0 and 2 are stores with st_ready=1 -> consume_count=1, st_commit=1; with st_ready=0 -> consume=0.
REQ-036 Slots 1 and 3 both write r5 with data 0xA/0xB -> only rf_wr_en[3]=1, writing 0xB.
REQ-037 Slot 2 has exception=1 with pc=0x80 -> cycle 1 retires 2 entries; cycle 2 retires nothing; cycle 3 exc_flush=1 with exc_pc=0x80; the unit holds in EXC_WAIT until rob_empty=1, then RUN.
REQ-038 reset_n=0 asserted in EXC_WAIT -> next edge returns RUN with retired_count=0 and exc_flush=0.

Source files
------------

// File: rtl/pipTypes.sv
// Shared pipeline types: ROB entry payload and retire state encoding.
package pipTypes;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  result_hi;
        logic [XLEN-1:0]  result_lo;
        logic [REG_W-1:0] dest_reg;
        logic             dest_reg_valid;
        logic             is_store;
        logic             hilo_write;
        logic             exception;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RUN,
        EXC_FLUSH,
        EXC_WAIT
    } retire_state_t;

endpackage

// File: rtl/retire_unit_if.sv
// ROB-head to retire-unit bundle; master is the ROB/commit side, slave is retire_unit.
interface retire_unit_if #(
    parameter int unsigned RET_COUNT    = 4,
    parameter int unsigned RETCOUNTLOG2 = $clog2(RET_COUNT)
);
    import pipTypes::*;

    rob_entry_t              slot_data [RET_COUNT];
    logic [RET_COUNT-1:0]    slot_valid;
    logic                    rob_empty;
    logic                    st_ready;

    logic                    consume;
    logic [RETCOUNTLOG2-1:0] consume_count;
    logic [RET_COUNT-1:0]    rf_wr_en;
    logic [REG_W-1:0]        rf_wr_reg  [RET_COUNT];
    logic [XLEN-1:0]         rf_wr_data [RET_COUNT];
    logic                    hilo_wr_en;
    logic [XLEN-1:0]         hi_data;
    logic [XLEN-1:0]         lo_data;
    logic                    st_commit;
    logic                    exc_flush;
    logic [XLEN-1:0]         exc_pc;
    logic [XLEN-1:0]         retired_count;

    modport master (
        output slot_data, slot_valid, rob_empty, st_ready,
        input  consume, consume_count, rf_wr_en, rf_wr_reg, rf_wr_data,
        input  hilo_wr_en, hi_data, lo_data, st_commit, exc_flush, exc_pc, retired_count
    );

    modport slave (
        input  slot_data, slot_valid, rob_empty, st_ready,
        output consume, consume_count, rf_wr_en, rf_wr_reg, rf_wr_data,
        output hilo_wr_en, hi_data, lo_data, st_commit, exc_flush, exc_pc, retired_count
    );

endinterface

// File: rtl/retire_select.sv
// Finds the retire group: the in-order valid prefix cut at an exception,
// a store that cannot issue, or a second HI/LO writer.
module retire_select #(
    parameter int unsigned RET_COUNT = 4,
    parameter int unsigned SIZE_W    = $clog2(RET_COUNT + 1)
) (
    input  logic                 enable,
    input  logic                 st_ready,
    input  logic [RET_COUNT-1:0] slot_valid,
    input  logic [RET_COUNT-1:0] is_store,
    input  logic [RET_COUNT-1:0] hilo_write,
    input  logic [RET_COUNT-1:0] exception,
    output logic [SIZE_W-1:0]    group_size,
    output logic [RET_COUNT-1:0] in_group
);

    logic open;
    logic seen_store;
    logic seen_hilo;

    always_comb begin
        in_group   = '0;
        group_size = '0;
        open       = enable;
        seen_store = 1'b0;
        seen_hilo  = 1'b0;
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            if (!slot_valid[i] || exception[i] ||
                (is_store[i] && (seen_store || !st_ready)) ||
                (hilo_write[i] && seen_hilo)) begin
                open = 1'b0;
            end
            if (open) begin
                in_group[i] = 1'b1;
                group_size  = group_size + SIZE_W'(1);
                seen_store  = seen_store | is_store[i];
                seen_hilo   = seen_hilo | hilo_write[i];
            end
        end
    end

endmodule

// File: rtl/retire_unit.sv
// Multi-slot in-order retire: commits the ROB head group to RF/HILO/store queue
// and sequences the precise-exception flush.
module retire_unit
    import pipTypes::*;
#(
    parameter int unsigned RET_COUNT    = 4,
    parameter int unsigned RETCOUNTLOG2 = $clog2(RET_COUNT)
) (
    input  logic         clock,
    input  logic         reset_n,
    retire_unit_if.slave bus
);

    localparam int unsigned SIZE_W = $clog2(RET_COUNT + 1);

    retire_state_t           state_q;
    retire_state_t           state_d;
    logic                    run_c;
    logic [RET_COUNT-1:0]    is_store_c;
    logic [RET_COUNT-1:0]    hilo_write_c;
    logic [RET_COUNT-1:0]    exception_c;
    logic [RET_COUNT-1:0]    in_group_c;
    logic [RET_COUNT-1:0]    rf_wr_en_c;
    logic [SIZE_W-1:0]       group_size_c;
    logic                    consume_c;
    logic [RETCOUNTLOG2-1:0] consume_count_c;
    logic [XLEN-1:0]         hi_c;
    logic [XLEN-1:0]         lo_c;
    logic [XLEN-1:0]         exc_pc_q;
    logic [XLEN-1:0]         retired_q;
    logic                    exc_flush_q;

    assign run_c = reset_n && (state_q == RUN);

    always_comb begin
        is_store_c   = '0;
        hilo_write_c = '0;
        exception_c  = '0;
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            is_store_c[i]   = bus.slot_data[i].is_store;
            hilo_write_c[i] = bus.slot_data[i].hilo_write;
            exception_c[i]  = bus.slot_data[i].exception;
        end
    end

    retire_select #(
        .RET_COUNT (RET_COUNT),
        .SIZE_W    (SIZE_W)
    ) u_select (
        .enable     (run_c),
        .st_ready   (bus.st_ready),
        .slot_valid (bus.slot_valid),
        .is_store   (is_store_c),
        .hilo_write (hilo_write_c),
        .exception  (exception_c),
        .group_size (group_size_c),
        .in_group   (in_group_c)
    );

    assign consume_c       = (group_size_c != '0);
    assign consume_count_c = consume_c ? RETCOUNTLOG2'(group_size_c - SIZE_W'(1)) : '0;

    // Only the youngest group member targeting a register keeps its write.
    always_comb begin
        rf_wr_en_c = '0;
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            rf_wr_en_c[i] = in_group_c[i] && bus.slot_data[i].dest_reg_valid &&
                            (bus.slot_data[i].dest_reg != '0);
            for (int j = i + 1; j < int'(RET_COUNT); j++) begin
                if (in_group_c[j] && bus.slot_data[j].dest_reg_valid &&
                    (bus.slot_data[j].dest_reg == bus.slot_data[i].dest_reg)) begin
                    rf_wr_en_c[i] = 1'b0;
                end
            end
        end
    end

    // At most one HI/LO writer can be in the group.
    always_comb begin
        hi_c = '0;
        lo_c = '0;
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            if (in_group_c[i] && hilo_write_c[i]) begin
                hi_c = bus.slot_data[i].result_hi;
                lo_c = bus.slot_data[i].result_lo;
            end
        end
    end

    always_comb begin
        bus.consume       = consume_c;
        bus.consume_count = consume_count_c;
        bus.rf_wr_en      = rf_wr_en_c;
        bus.hilo_wr_en    = |(in_group_c & hilo_write_c);
        bus.hi_data       = hi_c;
        bus.lo_data       = lo_c;
        bus.st_commit     = |(in_group_c & is_store_c);
        bus.exc_flush     = exc_flush_q;
        bus.exc_pc        = exc_pc_q;
        bus.retired_count = retired_q;
        for (int i = 0; i < int'(RET_COUNT); i++) begin
            bus.rf_wr_reg[i]  = reset_n ? bus.slot_data[i].dest_reg  : '0;
            bus.rf_wr_data[i] = reset_n ? bus.slot_data[i].result_lo : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:       if (bus.slot_valid[0] && bus.slot_data[0].exception) state_d = EXC_FLUSH;
            EXC_FLUSH: state_d = EXC_WAIT;
            EXC_WAIT:  if (bus.rob_empty) state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= RUN;
            exc_flush_q <= 1'b0;
            exc_pc_q    <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            exc_flush_q <= (state_d == EXC_FLUSH);
            if ((state_q == RUN) && (state_d == EXC_FLUSH)) begin
                exc_pc_q <= bus.slot_data[0].pc;
            end
            if (consume_c) begin
                retired_q <= retired_q + XLEN'(consume_count_c) + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: directed vector table, exception/reset sequences,
// and randomized traffic against a behavioural retire model.
module tb_retire_unit;
    import pipTypes::*;

    localparam int RC = 4;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    retire_unit_if #(.RET_COUNT(RC)) bus();

    retire_unit #(.RET_COUNT(RC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_cmp;
    int n_bad;

    // Reference model state: 0 = retiring, 1 = flush cycle, 2 = waiting for drain
    int          m_mode;
    logic [31:0] m_count;
    logic [31:0] m_pc;

    int          e_n;
    logic [3:0]  e_wr;
    logic        e_st;
    logic        e_hilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;

    typedef struct {
        string        name;
        logic [3:0]   valid;
        logic [3:0]   store;
        logic [3:0]   hilo;
        logic [3:0]   exc;
        logic [19:0]  dst;
        logic [127:0] data;
        logic         st_ready;
        int           exp_n;
        logic [3:0]   exp_wr;
        logic         exp_st;
        logic         exp_hilo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Retire rules applied directly to the visible slots.
    task automatic compute_exp();
        int          stores;
        int          hilos;
        logic        stop;
        logic [31:0] claimed;
        rob_entry_t  e;
        e_n = 0; e_wr = '0; e_st = 1'b0; e_hilo = 1'b0; e_hi = '0; e_lo = '0;
        stores = 0; hilos = 0; stop = 1'b0;
        if (reset_n === 1'b1 && m_mode == 0) begin
            for (int i = 0; i < RC; i++) begin
                e = bus.slot_data[i];
                if (!stop) begin
                    if (!bus.slot_valid[i] || e.exception ||
                        (e.is_store && (stores > 0 || !bus.st_ready)) ||
                        (e.hilo_write && hilos > 0)) begin
                        stop = 1'b1;
                    end else begin
                        e_n++;
                        if (e.is_store) begin stores++; e_st = 1'b1; end
                        if (e.hilo_write) begin
                            hilos++; e_hilo = 1'b1; e_hi = e.result_hi; e_lo = e.result_lo;
                        end
                    end
                end
            end
            claimed = '0;
            for (int i = e_n - 1; i >= 0; i--) begin
                e = bus.slot_data[i];
                if (e.dest_reg_valid && e.dest_reg != 5'd0 && !claimed[e.dest_reg]) begin
                    e_wr[i] = 1'b1;
                    claimed[e.dest_reg] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        compute_exp();
        chk("consume", 32'(bus.consume), 32'(e_n != 0));
        chk("consume_count", 32'(bus.consume_count), (e_n == 0) ? 32'd0 : 32'(e_n - 1));
        chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(e_wr));
        chk("st_commit", 32'(bus.st_commit), 32'(e_st));
        chk("hilo_wr_en", 32'(bus.hilo_wr_en), 32'(e_hilo));
        chk("hi_data", bus.hi_data, e_hi);
        chk("lo_data", bus.lo_data, e_lo);
        for (int i = 0; i < RC; i++) begin
            chk($sformatf("rf_wr_reg%0d", i), 32'(bus.rf_wr_reg[i]),
                (reset_n === 1'b1) ? 32'(bus.slot_data[i].dest_reg) : 32'd0);
            chk($sformatf("rf_wr_data%0d", i), bus.rf_wr_data[i],
                (reset_n === 1'b1) ? bus.slot_data[i].result_lo : 32'd0);
        end
        chk("exc_flush", 32'(bus.exc_flush), 32'(m_mode == 1));
        chk("exc_pc", bus.exc_pc, m_pc);
        chk("retired_count", bus.retired_count, m_count);
    endtask

    task automatic update_model();
        compute_exp();
        if (reset_n !== 1'b1) begin
            m_mode = 0; m_count = '0; m_pc = '0;
        end else if (m_mode == 0) begin
            m_count = m_count + 32'(e_n);
            if (bus.slot_valid[0] && bus.slot_data[0].exception) begin
                m_pc = bus.slot_data[0].pc;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (bus.rob_empty) begin
            m_mode = 0;
        end
    endtask

    task automatic settle_check();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clock);
        update_model();
        #1;
    endtask

    function automatic vec_t mk(string name, logic [3:0] valid, logic [3:0] store, logic [3:0] hilo,
                                logic [3:0] exc, logic [19:0] dst, logic [127:0] data, logic st_ready,
                                int exp_n, logic [3:0] exp_wr, logic exp_st, logic exp_hilo);
        vec_t v;
        v.name = name; v.valid = valid; v.store = store; v.hilo = hilo; v.exc = exc;
        v.dst = dst; v.data = data; v.st_ready = st_ready; v.exp_n = exp_n;
        v.exp_wr = exp_wr; v.exp_st = exp_st; v.exp_hilo = exp_hilo;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        rob_entry_t e;
        for (int i = 0; i < RC; i++) begin
            e = '0;
            e.pc             = 32'h200 + 32'(4 * i);
            e.result_hi      = 32'h900 + 32'(i);
            e.result_lo      = v.data[32*i +: 32];
            e.dest_reg       = v.dst[5*i +: 5];
            e.dest_reg_valid = 1'b1;
            e.is_store       = v.store[i];
            e.hilo_write     = v.hilo[i];
            e.exception      = v.exc[i];
            bus.slot_data[i] = e;
        end
        bus.slot_valid = v.valid;
        bus.st_ready   = v.st_ready;
        bus.rob_empty  = (v.valid == 4'b0000);
    endtask

    task automatic set_alu(input int i, input logic [4:0] dst, input logic [31:0] pc, input logic exc);
        rob_entry_t e;
        e = '0;
        e.pc = pc; e.result_lo = 32'h7000 + 32'(i); e.dest_reg = dst;
        e.dest_reg_valid = 1'b1; e.exception = exc;
        bus.slot_data[i] = e;
    endtask

    function automatic rob_entry_t rand_entry();
        rob_entry_t e;
        e = '0;
        e.pc             = $urandom;
        e.result_hi      = $urandom;
        e.result_lo      = $urandom;
        e.dest_reg       = 5'($urandom_range(0, 7));
        e.dest_reg_valid = ($urandom_range(0, 3) != 0);
        e.is_store       = ($urandom_range(0, 3) == 0);
        e.hilo_write     = ($urandom_range(0, 3) == 0);
        e.exception      = ($urandom_range(0, 11) == 0);
        return e;
    endfunction

    localparam logic [19:0]  D1234 = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [127:0] DAT   = {32'h40, 32'h30, 32'h20, 32'h10};

    logic [31:0] prev;

    initial begin
        n_cmp = 0; n_bad = 0;
        m_mode = 0; m_count = '0; m_pc = '0;
        reset_n = 1'b0;
        for (int i = 0; i < RC; i++) bus.slot_data[i] = '0;
        bus.slot_valid = '0; bus.rob_empty = 1'b1; bus.st_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, combinational outputs held low while reset is asserted
        set_alu(0, 5'd3, 32'h10, 1'b0);
        bus.slot_valid = 4'b0001; bus.rob_empty = 1'b0;
        settle_check();
        chk("reset_consume", 32'(bus.consume), 32'd0);
        chk("reset_count", bus.retired_count, 32'd0);
        chk("reset_flush", 32'(bus.exc_flush), 32'd0);
        tick();
        reset_n = 1'b1;

        tbl.push_back(mk("four_alu",     4'b1111, 4'b0000, 4'b0000, 4'b0000, D1234, DAT, 1'b1, 4, 4'b1111, 1'b0, 1'b0));
        tbl.push_back(mk("gap_slot2",    4'b1011, 4'b0000, 4'b0000, 4'b0000, D1234, DAT, 1'b1, 2, 4'b0011, 1'b0, 1'b0));
        tbl.push_back(mk("two_st_rdy",   4'b1111, 4'b0101, 4'b0000, 4'b0000, D1234, DAT, 1'b1, 2, 4'b0011, 1'b1, 1'b0));
        tbl.push_back(mk("two_st_busy",  4'b1111, 4'b0101, 4'b0000, 4'b0000, D1234, DAT, 1'b0, 0, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk("same_r5",      4'b1111, 4'b0000, 4'b0000, 4'b0000, {5'd5, 5'd7, 5'd5, 5'd6},
                         {32'hB, 32'h30, 32'hA, 32'h10}, 1'b1, 4, 4'b1101, 1'b0, 1'b0));
        tbl.push_back(mk("r0_dest",      4'b1111, 4'b0000, 4'b0000, 4'b0000, {5'd3, 5'd2, 5'd1, 5'd0}, DAT, 1'b1, 4, 4'b1110, 1'b0, 1'b0));
        tbl.push_back(mk("two_hilo",     4'b1111, 4'b0000, 4'b1010, 4'b0000, D1234, DAT, 1'b1, 3, 4'b0111, 1'b0, 1'b1));
        tbl.push_back(mk("exc_slot2",    4'b1111, 4'b0000, 4'b0000, 4'b0100, D1234, DAT, 1'b1, 2, 4'b0011, 1'b0, 1'b0));
        tbl.push_back(mk("empty",        4'b0000, 4'b0000, 4'b0000, 4'b0000, D1234, DAT, 1'b1, 0, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk("slot0_invld",  4'b1110, 4'b0000, 4'b0000, 4'b0000, D1234, DAT, 1'b1, 0, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk("late_st_busy", 4'b1111, 4'b1000, 4'b0000, 4'b0000, D1234, DAT, 1'b0, 3, 4'b0111, 1'b0, 1'b0));
        tbl.push_back(mk("st_slot0",     4'b1111, 4'b0001, 4'b0000, 4'b0000, D1234, DAT, 1'b1, 4, 4'b1111, 1'b1, 1'b0));

        foreach (tbl[k]) begin
            apply_vec(tbl[k]);
            settle_check();
            chk({tbl[k].name, "_consume"}, 32'(bus.consume), 32'(tbl[k].exp_n != 0));
            chk({tbl[k].name, "_cnt"}, 32'(bus.consume_count),
                (tbl[k].exp_n == 0) ? 32'd0 : 32'(tbl[k].exp_n - 1));
            chk({tbl[k].name, "_wr_en"}, 32'(bus.rf_wr_en), 32'(tbl[k].exp_wr));
            chk({tbl[k].name, "_st"}, 32'(bus.st_commit), 32'(tbl[k].exp_st));
            chk({tbl[k].name, "_hilo"}, 32'(bus.hilo_wr_en), 32'(tbl[k].exp_hilo));
            chk({tbl[k].name, "_data3"}, bus.rf_wr_data[3], tbl[k].data[127:96]);
            prev = bus.retired_count;
            tick();
            chk({tbl[k].name, "_retired"}, bus.retired_count, prev + 32'(tbl[k].exp_n));
        end

        // Exception in slot 2 walks to the head, flushes, then waits for drain
        for (int i = 0; i < RC; i++) set_alu(i, 5'(i + 1), 32'h80 - 32'(8 * (2 - i)), 1'b0);
        set_alu(2, 5'd3, 32'h80, 1'b1);
        bus.slot_valid = 4'b1111; bus.rob_empty = 1'b0; bus.st_ready = 1'b1;
        settle_check();
        chk("exc_c1_cnt", 32'(bus.consume_count), 32'd1);
        tick();
        set_alu(0, 5'd3, 32'h80, 1'b1);
        set_alu(1, 5'd4, 32'h84, 1'b0);
        bus.slot_valid = 4'b0011;
        settle_check();
        chk("exc_c2_consume", 32'(bus.consume), 32'd0);
        tick();
        settle_check();
        chk("exc_c3_flush", 32'(bus.exc_flush), 32'd1);
        chk("exc_c3_pc", bus.exc_pc, 32'h80);
        chk("exc_c3_consume", 32'(bus.consume), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            settle_check();
            chk("exc_wait_flush", 32'(bus.exc_flush), 32'd0);
            chk("exc_wait_consume", 32'(bus.consume), 32'd0);
            tick();
        end
        bus.slot_valid = 4'b0000; bus.rob_empty = 1'b1;
        settle_check();
        tick();
        set_alu(0, 5'd9, 32'h300, 1'b0);
        bus.slot_valid = 4'b0001; bus.rob_empty = 1'b0;
        settle_check();
        chk("exc_back_run", 32'(bus.consume), 32'd1);
        chk("exc_pc_held", bus.exc_pc, 32'h80);
        tick();

        // Reset while waiting for drain
        set_alu(0, 5'd2, 32'h444, 1'b1);
        bus.slot_valid = 4'b0001;
        settle_check();
        tick();
        settle_check();
        tick();
        settle_check();
        chk("rst_wait_consume", 32'(bus.consume), 32'd0);
        reset_n = 1'b0;
        settle_check();
        chk("rst_low_reg0", 32'(bus.rf_wr_reg[0]), 32'd0);
        tick();
        reset_n = 1'b1;
        set_alu(0, 5'd2, 32'h448, 1'b0);
        settle_check();
        chk("rst_count", bus.retired_count, 32'd0);
        chk("rst_flush", 32'(bus.exc_flush), 32'd0);
        chk("rst_run", 32'(bus.consume), 32'd1);
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < RC; i++) bus.slot_data[i] = rand_entry();
            bus.rob_empty  = ($urandom_range(0, 5) == 0);
            bus.slot_valid = bus.rob_empty ? 4'b0000 :
                             (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111);
            bus.st_ready   = ($urandom_range(0, 3) != 0);
            reset_n        = ($urandom_range(0, 79) != 0);
            settle_check();
            tick();
        end
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
